// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, decode handshake and branch redirect.
interface fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid;
    logic [31:0]       imem_rdata;
    logic [31:0]       instruction;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] pc_plus8;
    logic              instr_valid;
    logic              dec_ready;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;

    modport master (
        output imem_req, imem_addr, instruction, pc_out, pc_plus8, instr_valid,
        input  imem_valid, imem_rdata, dec_ready, branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, instruction, pc_out, pc_plus8, instr_valid,
        output imem_valid, imem_rdata, dec_ready, branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory request in flight,
// buffers returned words in a small FIFO for decode and handles branch redirects.
//
// state  | meaning
// S_IDLE | no request outstanding; may issue when FIFO has space
// S_WAIT | one request outstanding; its response will be pushed
// S_DROP | one request outstanding but made stale by a redirect; discard it
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [31:0]       mem_instr_q [DEPTH];
    logic [31:0]       mem_instr_d [DEPTH];
    logic [ADDR_W-1:0] mem_pc_q [DEPTH];
    logic [ADDR_W-1:0] mem_pc_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       last_instr_q, last_instr_d;
    logic [ADDR_W-1:0] last_pc_q, last_pc_d;

    logic              not_empty;
    logic              has_space;
    logic              issue;
    logic              push;
    logic              pop;
    logic [31:0]       head_instr;
    logic [ADDR_W-1:0] head_pc;

    always_comb begin
        not_empty = (count_q != '0);
        has_space = (count_q < CNT_W'(DEPTH));
        issue     = (state_q == S_IDLE) && has_space && !bus.branch_taken;
        push      = (state_q == S_WAIT) && bus.imem_valid && !bus.branch_taken;
        pop       = not_empty && bus.dec_ready && !bus.branch_taken;

        // Head outputs come only from flops; an empty FIFO shows the last head seen.
        head_instr = not_empty ? mem_instr_q[rd_ptr_q] : last_instr_q;
        head_pc    = not_empty ? mem_pc_q[rd_ptr_q]    : last_pc_q;
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_addr_d   = req_addr_q;
        mem_instr_d  = mem_instr_q;
        mem_pc_d     = mem_pc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        last_instr_d = head_instr;
        last_pc_d    = head_pc;

        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d    = S_WAIT;
                    req_addr_d = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                end
            end
            S_WAIT: begin
                if (bus.imem_valid) begin
                    state_d = S_IDLE;
                end else if (bus.branch_taken) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (bus.imem_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            mem_instr_d[wr_ptr_q] = bus.imem_rdata;
            mem_pc_d[wr_ptr_q]    = req_addr_q;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Redirect wins over everything: flush and restart at the word-aligned target.
        if (bus.branch_taken) begin
            fetch_pc_d = bus.branch_target & ~ADDR_W'(3);
            rd_ptr_d   = wr_ptr_q;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            req_addr_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_instr_q <= '0;
            last_pc_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= '0;
                mem_pc_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_addr_q   <= req_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_instr_q <= last_instr_d;
            last_pc_q    <= last_pc_d;
            mem_instr_q  <= mem_instr_d;
            mem_pc_q     <= mem_pc_d;
        end
    end

    // The request strobe is combinational, so it is gated by reset to stay low while held.
    assign bus.imem_req    = issue && rst;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = not_empty;
    assign bus.instruction = head_instr;
    assign bus.pc_out      = head_pc;
    assign bus.pc_plus8    = head_pc + ADDR_W'(8);

endmodule
